clk_div_gen_multi: RTL and testbench
====================================

Name: clk_div_gen_multi

Overview:
- Parametrised multi-channel clock generator for QVIP/UVMF testbench harnesses. Successor to the fixed free-running divide-by-2 generator.
- Derives NUM_CH independent divided clocks from one source clock.
- Each channel has a programmable period and high time, glitch-free start/stop, and config updates that take effect only at period boundaries.
- Also produces a stretched, synchronously released reset for the DUT and agents.

Parameters:
- NUM_CH, 2: number of output clock channels, 1..16.
- DIV_W, 8: width of the period and high-time fields.
- DEF_DIV, 2: reset-value period, in CLK cycles, for every channel.
- DEF_HIGH, 1: reset-value high time, in CLK cycles, for every channel.
- RST_HOLD, 4: CLK cycles that rst_out stays asserted after RST deasserts, 1..255.

Ports:
- CLK  input  1: source clock; all logic is on its rising edge.
- RST  input  1: asynchronous, active-high reset.
- cfg_valid  input  1: config request.
- cfg_ready  output  1: config accept. Equals ~pending[cfg_ch].
- cfg_ch  input  max(1,$clog2(NUM_CH)): target channel.
- cfg_div  input  DIV_W: requested period, in CLK cycles.
- cfg_high  input  DIV_W: requested high time, in CLK cycles.
- ch_en  input  NUM_CH: per-channel run request.
- clk_out  output  NUM_CH: divided clocks, registered.
- clk_rise  output  NUM_CH: one-CLK strobe, high in the cycle clk_out rises.
- running  output  NUM_CH: channel is in RUN or STOP state.
- rst_out  output  1: stretched active-high reset.

Behaviour:
- Reset values while RST is high:
  - clk_out=0, clk_rise=0, running=0, rst_out=1.
  - All channels IDLE, count=0, pending=0.
  - Active and shadow config = DEF_DIV/DEF_HIGH.
  - cfg_ready follows ~pending, so it reads 1.
- rst_out:
  - Asserts asynchronously with RST.
  - After RST falls, a hold counter counts CLK edges. rst_out goes 0 on the RST_HOLD-th rising edge.
  - An RST pulse during the hold period restarts the count.
- Config handshake:
  - A transfer happens when cfg_valid & cfg_ready at a CLK edge. It writes the shadow for cfg_ch and sets pending[cfg_ch].
  - Clamping is applied on capture:
    - div < 2 becomes 2.
    - high = 0 becomes 1.
    - high >= div becomes div-1.
  - Shadow to active copy, clearing pending:
    - IDLE channel: on the next edge.
    - RUN channel: on the edge where count wraps to 0, so a new period never starts mid-cycle.
  - Transfers to other channels are independent.
- Per-channel state machine (IDLE, RUN, STOP):
  - IDLE --ch_en=1--> RUN: count=0, clk_out=1, clk_rise=1. clk_out rises one cycle after ch_en is sampled high.
  - RUN:
    - count increments each cycle and wraps at div-1.
    - clk_out = (count < high), registered alongside count.
    - clk_rise=1 on each cycle where count==0.
  - RUN --ch_en=0--> STOP: the current period finishes.
  - STOP at wrap: goes to IDLE with clk_out=0 and no clk_rise.
  - STOP --ch_en=1 before wrap--> RUN, with no phase disturbance.
  - running = (state != IDLE).
- Boundary conditions:
  - A config capture and a wrap on the same edge: the wrap uses the old active config. The new shadow applies at the next wrap.
  - ch_en rising in the same cycle as a config to an IDLE channel: the first period uses the new config.
  - Minimum output is div=2, high=1, giving CLK/2 at 50% duty.
  - Maximum period is 2^DIV_W-1.
  - RST mid-operation: all clk_out drop to 0 asynchronously; state returns to IDLE; active and shadow config return to DEF_DIV/DEF_HIGH.
  - Channels are independent: no phase relationship is guaranteed unless they are enabled in the same cycle with equal configs, in which case their outputs are identical.

Test Plan:
- Reset and hold:
  - Stimulus: assert RST for 3 cycles, release, RST_HOLD=4.
  - Required: rst_out is 1 through the release and falls on the 4th rising edge; all clk_out=0.
- Default run:
  - Stimulus: ch_en[0]=1 after reset.
  - Required: clk_out[0] toggles 1,0,1,0 (CLK/2); clk_rise[0] high every 2nd cycle starting 1 cycle after enable.
- Programmed ratio:
  - Stimulus: cfg ch1 with div=5, high=2; enable ch1.
  - Required: clk_out[1] pattern 1,1,0,0,0 repeating; clk_rise[1] once per 5 cycles.
- Boundary-aligned update:
  - Stimulus: ch0 running div=4/high=2; mid-period, write div=6/high=3.
  - Required: the current 1100 period completes, then 111000 follows. cfg_ready for ch0 is low until the wrap.
  - Required: a second write before the wrap stalls and is not lost.
- Clamping:
  - Stimulus: cfg div=0, high=0.
  - Required: behaves as div=2/high=1.
  - Stimulus: cfg div=3, high=9.
  - Required: behaves as div=3/high=2 (pattern 110).
- Stop and async reset:
  - Stimulus: drop ch_en mid-period.
  - Required: the period finishes, clk_out ends at 0, running falls on the wrap edge.
  - Stimulus: re-run the channel, then assert RST mid-high.
  - Required: clk_out drops to 0 immediately without waiting for a CLK edge.

Source files
------------

// File: rtl/clk_div_gen_multi.sv
// Multi-channel programmable clock divider with glitch-free start/stop,
// period-boundary config updates and a stretched synchronous-release reset.
module clk_div_gen_multi #(
   parameter int NUM_CH   = 2,
   parameter int DIV_W    = 8,
   parameter int DEF_DIV  = 2,
   parameter int DEF_HIGH = 1,
   parameter int RST_HOLD = 4,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [DIV_W-1:0]  cfg_high,
   input  logic [NUM_CH-1:0] ch_en,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] clk_rise,
   output logic [NUM_CH-1:0] running,
   output logic              rst_out
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_STOP = 2'd2} ch_state_t;

   localparam logic [DIV_W-1:0] DEF_DIV_V  = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] DEF_HIGH_V = DIV_W'(DEF_HIGH);
   localparam logic [7:0]       HOLD_LAST  = 8'(RST_HOLD - 1);

   ch_state_t         state_q    [NUM_CH];
   ch_state_t         state_d    [NUM_CH];
   logic [DIV_W-1:0]  count_q    [NUM_CH];
   logic [DIV_W-1:0]  count_d    [NUM_CH];
   logic [DIV_W-1:0]  div_act_q  [NUM_CH];
   logic [DIV_W-1:0]  div_act_d  [NUM_CH];
   logic [DIV_W-1:0]  high_act_q [NUM_CH];
   logic [DIV_W-1:0]  high_act_d [NUM_CH];
   logic [DIV_W-1:0]  div_sh_q   [NUM_CH];
   logic [DIV_W-1:0]  div_sh_d   [NUM_CH];
   logic [DIV_W-1:0]  high_sh_q  [NUM_CH];
   logic [DIV_W-1:0]  high_sh_d  [NUM_CH];
   logic [NUM_CH-1:0] pending_q, pending_d;
   logic [NUM_CH-1:0] clk_out_q, clk_out_d;
   logic [NUM_CH-1:0] rise_q, rise_d;
   logic [NUM_CH-1:0] cap, wrap;
   logic [DIV_W-1:0]  div_c, high_c;
   logic [7:0]        hold_cnt;

   // Handshake: a transfer occurs on any CLK edge where cfg_valid and
   // cfg_ready are both high; cfg_ready depends only on pending[cfg_ch].
   // An out-of-range channel reads ready and the write is dropped.
   assign cfg_ready = (int'(cfg_ch) < NUM_CH) ? ~pending_q[cfg_ch] : 1'b1;
   assign clk_out   = clk_out_q;
   assign clk_rise  = rise_q;

   always_comb begin
      div_c = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
      if (cfg_high == '0)          high_c = DIV_W'(1);
      else if (cfg_high >= div_c)  high_c = div_c - DIV_W'(1);
      else                         high_c = cfg_high;
   end

   always_comb begin
      cap     = '0;
      wrap    = '0;
      running = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cap[i]     = cfg_valid && cfg_ready && (int'(cfg_ch) == i);
         wrap[i]    = (count_q[i] == div_act_q[i] - DIV_W'(1));
         running[i] = (state_q[i] != S_IDLE);
      end
   end

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      div_act_d  = div_act_q;
      high_act_d = high_act_q;
      div_sh_d   = div_sh_q;
      high_sh_d  = high_sh_q;
      pending_d  = pending_q;
      clk_out_d  = clk_out_q;
      rise_d     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cap[i]) begin
            div_sh_d[i]  = div_c;
            high_sh_d[i] = high_c;
            pending_d[i] = 1'b1;
         end
         case (state_q[i])
            S_IDLE: begin
               count_d[i]   = '0;
               clk_out_d[i] = 1'b0;
               if (ch_en[i]) begin
                  state_d[i]   = S_RUN;
                  clk_out_d[i] = 1'b1;
                  rise_d[i]    = 1'b1;
                  // A write landing with the enable defines the first period.
                  if (cap[i]) begin
                     div_act_d[i]  = div_c;
                     high_act_d[i] = high_c;
                     pending_d[i]  = 1'b0;
                  end else if (pending_q[i]) begin
                     div_act_d[i]  = div_sh_q[i];
                     high_act_d[i] = high_sh_q[i];
                     pending_d[i]  = 1'b0;
                  end
               end else if (pending_q[i]) begin
                  div_act_d[i]  = div_sh_q[i];
                  high_act_d[i] = high_sh_q[i];
                  pending_d[i]  = 1'b0;
               end
            end
            S_RUN, S_STOP: begin
               if (wrap[i]) begin
                  count_d[i] = '0;
                  if (pending_q[i]) begin
                     div_act_d[i]  = div_sh_q[i];
                     high_act_d[i] = high_sh_q[i];
                     pending_d[i]  = 1'b0;
                  end
                  state_d[i]   = ch_en[i] ? S_RUN : S_IDLE;
                  clk_out_d[i] = ch_en[i];
                  rise_d[i]    = ch_en[i];
               end else begin
                  count_d[i]   = count_q[i] + DIV_W'(1);
                  clk_out_d[i] = (count_q[i] + DIV_W'(1)) < high_act_q[i];
                  state_d[i]   = ch_en[i] ? S_RUN : S_STOP;
               end
            end
            default: begin
               state_d[i]   = S_IDLE;
               count_d[i]   = '0;
               clk_out_d[i] = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]    <= S_IDLE;
            count_q[i]    <= '0;
            div_act_q[i]  <= DEF_DIV_V;
            high_act_q[i] <= DEF_HIGH_V;
            div_sh_q[i]   <= DEF_DIV_V;
            high_sh_q[i]  <= DEF_HIGH_V;
         end
         pending_q <= '0;
         clk_out_q <= '0;
         rise_q    <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         div_act_q  <= div_act_d;
         high_act_q <= high_act_d;
         div_sh_q   <= div_sh_d;
         high_sh_q  <= high_sh_d;
         pending_q  <= pending_d;
         clk_out_q  <= clk_out_d;
         rise_q     <= rise_d;
      end
   end

   // rst_out clears on the RST_HOLD-th edge after release; RST restarts it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         rst_out  <= 1'b1;
         hold_cnt <= '0;
      end else if (rst_out) begin
         if (hold_cnt == HOLD_LAST) rst_out  <= 1'b0;
         else                       hold_cnt <= hold_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_clk_div_gen_multi.sv
// Bench for clk_div_gen_multi: a period-waveform model checked every cycle,
// plus directed sequences with hand-computed literal patterns.
module tb_clk_div_gen_multi;

   localparam int NUM_CH   = 2;
   localparam int DIV_W    = 8;
   localparam int DEF_DIV  = 2;
   localparam int DEF_HIGH = 1;
   localparam int RST_HOLD = 4;
   localparam int CH_W     = 1;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [DIV_W-1:0]  cfg_div = '0;
   logic [DIV_W-1:0]  cfg_high = '0;
   logic [NUM_CH-1:0] ch_en = '0;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] clk_rise;
   logic [NUM_CH-1:0] running;
   logic              rst_out;

   int total = 0;
   int bad   = 0;

   clk_div_gen_multi #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV),
      .DEF_HIGH(DEF_HIGH), .RST_HOLD(RST_HOLD)
   ) dut (
      .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high), .ch_en(ch_en),
      .clk_out(clk_out), .clk_rise(clk_rise), .running(running), .rst_out(rst_out)
   );

   always #5 CLK = ~CLK;

   // ---------------- model: each period is a precomputed waveform ----------------
   int                m_div   [NUM_CH] = '{default: DEF_DIV};
   int                m_high  [NUM_CH] = '{default: DEF_HIGH};
   int                m_sdiv  [NUM_CH] = '{default: DEF_DIV};
   int                m_shigh [NUM_CH] = '{default: DEF_HIGH};
   bit                m_wave  [NUM_CH][$];
   logic [NUM_CH-1:0] m_pend = '0;
   logic [NUM_CH-1:0] m_run  = '0;
   logic [NUM_CH-1:0] m_out  = '0;
   logic [NUM_CH-1:0] m_rise = '0;
   int                m_hold = 0;
   logic              h0[$], h1[$], hr0[$], hr1[$];

   task automatic model_step();
      int  cdiv, chigh;
      bit  take, mine, used;
      if (RST) begin
         m_hold = 0;
         m_pend = '0; m_run = '0; m_out = '0; m_rise = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF_DIV;  m_high[i] = DEF_HIGH;
            m_sdiv[i] = DEF_DIV; m_shigh[i] = DEF_HIGH;
            m_wave[i].delete();
         end
         return;
      end
      if (m_hold < RST_HOLD) m_hold++;
      cdiv  = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
      chigh = (int'(cfg_high) == 0) ? 1 :
              (int'(cfg_high) >= cdiv) ? cdiv - 1 : int'(cfg_high);
      take  = cfg_valid && !m_pend[cfg_ch];
      for (int i = 0; i < NUM_CH; i++) begin
         mine = take && (int'(cfg_ch) == i);
         used = 1'b0;
         m_rise[i] = 1'b0;
         if (m_wave[i].size() > 0) begin
            m_out[i] = m_wave[i].pop_front();
         end else begin
            if (m_pend[i]) begin
               m_div[i] = m_sdiv[i]; m_high[i] = m_shigh[i]; m_pend[i] = 1'b0;
            end
            if (ch_en[i]) begin
               if (!m_run[i] && mine) begin
                  m_div[i] = cdiv; m_high[i] = chigh; used = 1'b1;
               end
               for (int k = 0; k < m_div[i]; k++) m_wave[i].push_back(k < m_high[i]);
               m_out[i]  = m_wave[i].pop_front();
               m_rise[i] = 1'b1;
               m_run[i]  = 1'b1;
            end else begin
               m_run[i] = 1'b0;
               m_out[i] = 1'b0;
            end
         end
         if (mine && !used) begin
            m_sdiv[i] = cdiv; m_shigh[i] = chigh; m_pend[i] = 1'b1;
         end
      end
   endtask

   initial forever begin
      @(posedge CLK or posedge RST);
      model_step();
   end

   // ---------------- scoreboard helpers ----------------
   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void check_seq(input string name, input logic q[$], input int start,
                                     input logic [31:0] bits, input int n);
      for (int k = 0; k < n; k++)
         check($sformatf("%s[%0d]", name, k), 32'(q[start + k]), 32'(bits[n - 1 - k]));
   endfunction

   initial forever begin
      @(negedge CLK);
      check("rst_out",   32'(rst_out),   32'(m_hold < RST_HOLD));
      check("clk_out",   32'(clk_out),   32'(m_out));
      check("clk_rise",  32'(clk_rise),  32'(m_rise));
      check("running",   32'(running),   32'(m_run));
      check("cfg_ready", 32'(cfg_ready), 32'(!m_pend[cfg_ch]));
      h0.push_back(clk_out[0]);   h1.push_back(clk_out[1]);
      hr0.push_back(clk_rise[0]); hr1.push_back(clk_rise[1]);
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge CLK);
      #1;
   endtask

   task automatic set_en(input logic [NUM_CH-1:0] m);
      @(negedge CLK);
      #1;
      ch_en = m;
   endtask

   task automatic cfg_write(input int ch, input int dv, input int hi);
      logic acc;
      acc       = 1'b0;
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(ch);
      cfg_div   = DIV_W'(dv);
      cfg_high  = DIV_W'(hi);
      for (int k = 0; k < 64 && !acc; k++) begin
         #1;
         acc = cfg_ready;
         @(posedge CLK);
         @(negedge CLK);
         #1;
      end
      cfg_valid = 1'b0;
      check("cfg_accept", 32'(acc), 32'd1);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin
      int mk0, mk1;
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK); #1;
      check("reset_rst_out", 32'(rst_out),   32'd1);
      check("reset_clk_out", 32'(clk_out),   32'd0);
      check("reset_running", 32'(running),   32'd0);
      check("reset_ready",   32'(cfg_ready), 32'd1);
      RST = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         check($sformatf("rst_hold_edge%0d", k), 32'(rst_out), (k < 4) ? 32'd1 : 32'd0);
      end

      // default CLK/2 on ch0
      set_en(2'b01);
      mk0 = h0.size();
      step(4);
      check_seq("default_out0",  h0,  mk0, 32'b1010, 4);
      check_seq("default_rise0", hr0, mk0, 32'b1010, 4);
      set_en(2'b00);
      step(4);

      // ch1 at 5/2
      cfg_write(1, 5, 2);
      set_en(2'b10);
      mk1 = h1.size();
      step(10);
      check_seq("ratio_out1",  h1,  mk1, 32'b11000_11000, 10);
      check_seq("ratio_rise1", hr1, mk1, 32'b10000_10000, 10);
      set_en(2'b00);
      step(6);

      // boundary-aligned update on ch0, second write stalls until the wrap
      cfg_write(0, 4, 2);
      set_en(2'b01);
      mk0 = h0.size();
      step(2);
      cfg_write(0, 6, 3);
      check("update_ready_low", 32'(cfg_ready), 32'd0);
      cfg_write(0, 3, 9);
      step(12);
      check_seq("update_out0", h0, mk0, 32'b1100_111000_110110, 16);
      set_en(2'b00);
      step(8);

      // clamp div=0/high=0 -> 2/1
      cfg_write(0, 0, 0);
      set_en(2'b01);
      mk0 = h0.size();
      step(4);
      check_seq("clamp_min_out0", h0, mk0, 32'b1010, 4);
      set_en(2'b00);
      step(4);

      // clamp div=3/high=9 -> 3/2, written in the same cycle as the enable
      ch_en = 2'b01;
      mk0 = h0.size();
      cfg_write(0, 3, 9);
      step(6);
      check_seq("clamp_high_out0", h0, mk0, 32'b110110, 6);

      // stop mid-period on ch1 (still 5/2)
      set_en(2'b10);
      step(1);
      ch_en = 2'b00;
      step(4);
      check("stop_running_last", 32'(running[1]), 32'd1);
      check("stop_out_last",     32'(clk_out[1]), 32'd0);
      step(1);
      check("stop_running_wrap", 32'(running[1]), 32'd0);

      // async reset while ch1 is high
      set_en(2'b10);
      step(1);
      check("async_pre_high", 32'(clk_out[1]), 32'd1);
      #2;
      RST   = 1'b1;
      ch_en = 2'b00;
      #1;
      check("async_clk_out", 32'(clk_out), 32'd0);
      check("async_running", 32'(running), 32'd0);
      check("async_rst_out", 32'(rst_out), 32'd1);
      step(2);
      RST = 1'b0;
      step(6);

      // config back to defaults; same-cycle enable gives identical outputs
      set_en(2'b11);
      mk0 = h0.size();
      mk1 = h1.size();
      step(4);
      check_seq("post_rst_out0", h0, mk0, 32'b1010, 4);
      check_seq("post_rst_out1", h1, mk1, 32'b1010, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
